boot_loader: RTL and testbench
==============================

# boot_loader

Loads a program image into the CPU's 256-word instruction memory from an 8-bit byte stream, then releases the CPU to run. It sits directly upstream of the CPU: it drives the instruction memory write port and holds the CPU's run enable low until a complete, checksum-verified image has been written.

## Interface
- TIMEOUT, 1000: maximum idle cycles between accepted bytes during PAYLOAD/CHECK before aborting; 0 disables the timeout.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- start  in  1  single-cycle pulse; restarts a load from DONE or ERROR.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  8  instruction memory word address.
- imem_wdata  out  32  instruction word to write.
- cpu_run  out  1  high releases the CPU; low holds it in reset.
- done  out  1  image loaded and verified.
- error  out  1  checksum mismatch or timeout.

## Operation
- Image format: count byte N, then N×4 payload bytes, then checksum byte C. N=0 means 256 words.
- Word assembly is big-endian: first byte → imem_wdata[31:24], fourth byte → [7:0].
- Word k is written at imem_addr=k; the first word goes to address 0.
- Checksum rule: (N + sum of all payload bytes + C) mod 256 must equal 0.
- A byte is accepted on a rising edge where in_valid && in_ready. Bytes presented while in_ready=0 are not consumed.
- States:
  - IDLE: entered only via reset; unconditionally → HDR next cycle.
  - HDR: in_ready=1. On accept, latch N, seed the running sum with N, clear the address and byte counters → PAYLOAD. No timeout applies.
  - PAYLOAD: in_ready=1. Shift each byte into the word register and add it to the sum. On the 4th byte of a word → WRITE.
  - WRITE: one cycle. in_ready=0, imem_we=1, imem_addr = word index. Then:
    - if words written < N (N=0 counts as 256): increment the address → PAYLOAD;
    - otherwise → CHECK.
  - CHECK: in_ready=1. On accept, → DONE if the checksum rule holds, else → ERROR.
  - DONE: done=1, cpu_run=1, in_ready=0.
  - ERROR: error=1, cpu_run=0, in_ready=0.
- From DONE or ERROR, start=1 → HDR. Entering HDR clears done, error and cpu_run.
- start is ignored in all other states.
- Timeout counter:
  - clears on every accepted byte and on entry to PAYLOAD;
  - increments each PAYLOAD/CHECK cycle without a handshake;
  - holds during WRITE;
  - reaching TIMEOUT → ERROR.
- Arithmetic: the address counter is 8 bits. With N=0 it runs 0..255; the 256th write is detected by the word counter (9 bits), not by address wrap. The sum is 8-bit modulo.

## Timing
- Reset values (asserted asynchronously, held while reset=0): state IDLE; in_ready, imem_we, imem_addr, imem_wdata, cpu_run, done and error all 0.
- The first cycle after reset deassertion is IDLE; in_ready rises the following cycle.
- imem_we/imem_addr/imem_wdata are registered and valid together in the WRITE cycle, i.e. one cycle after the 4th byte of the word is accepted.
- Peak throughput is 4 bytes per 5 cycles.
- done or error and cpu_run change one cycle after the checksum byte is accepted.
- A timeout asserts error in the cycle after the counter reaches TIMEOUT.
- Reset mid-load: the partial word is discarded and no further write occurs. Memory words already written stay as written. The next load starts at address 0.
- start arriving in the same cycle the FSM enters DONE/ERROR is ignored.

## Test plan
- Good load: bytes 02,01,02,03,04,05,06,07,08,DA → writes addr0=0x01020304 then addr1=0x05060708, each a 1-cycle imem_we. Then done=1, cpu_run=1, error=0.
- Bad checksum: same image with C=DB → no done; error=1, cpu_run=0. A start pulse then returns to HDR (error=0, in_ready=1), and a good reload reaches done.
- Back-pressure: hold in_valid=1 continuously → in_ready drops in each WRITE cycle, no byte is lost or duplicated, and the written words match the good-load case.
- Timeout: TIMEOUT=16, send 02,01,02,03 then idle → error=1 exactly 17 cycles after the last accept, and no imem_we occurs.
- Reset mid-payload: assert reset after 6 payload bytes → all outputs go to 0 immediately. A fresh good load then writes from addr 0.
- Full image: N=00 with 1024 bytes → 256 writes at addresses 0..255 in order, then CHECK, then done with the correct checksum.

Source files
------------

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream program image loader for the CPU instruction memory
//
// Receives an image (count byte N, N*4 payload bytes, checksum byte C) on an
// 8-bit valid/ready stream, writes big-endian 32-bit words into a 256-word
// instruction memory, and releases the CPU only once the checksum verifies.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   in_valid    source presents a byte on in_data
//   in_data     stream byte
//   in_ready    loader accepts the byte this cycle
//   start       single-cycle pulse, restarts a load from DONE or ERROR
//   imem_we     instruction memory write strobe (one cycle per word)
//   imem_addr   instruction memory word address
//   imem_wdata  instruction word
//   cpu_run     high releases the CPU
//   done        image loaded and verified
//   error       checksum mismatch or inter-byte timeout
module boot_loader #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic        TMO_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [7:0]    r_n;       // latched word count byte (0 means 256)
  logic [7:0]    r_sum;     // running modulo-256 checksum
  logic [7:0]    r_addr;    // current word address
  logic [8:0]    r_wcnt;    // words written so far; 9 bits so 256 is representable
  logic [1:0]    r_bcnt;    // byte position within the current word
  logic [31:0]   r_word;    // word assembly shift register
  logic [TW-1:0] r_tmo;     // idle cycles since last accepted byte

  logic          w_accept;
  logic          w_timed_out;
  logic          w_more;
  logic          w_sum_ok;
  logic [7:0]    w_sum_add;
  logic [8:0]    w_nwords;
  logic [8:0]    w_wcnt_inc;

  assign w_accept    = in_valid && in_ready;
  assign w_sum_add   = r_sum + in_data;
  assign w_sum_ok    = (w_sum_add == 8'd0);
  assign w_nwords    = (r_n == 8'd0) ? 9'd256 : {1'b0, r_n};
  assign w_wcnt_inc  = r_wcnt + 9'd1;
  assign w_more      = (w_wcnt_inc < w_nwords);
  assign w_timed_out = TMO_EN && (r_tmo == TW'(TIMEOUT));

  assign imem_addr   = r_addr;
  assign imem_wdata  = r_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs. Once the idle counter has expired,
  // in_ready is withheld so no byte is consumed on the way to ERROR.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_run  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_HDR;
      end
      S_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_timed_out) begin
          w_next = S_ERROR;
        end else begin
          in_ready = 1'b1;
          if (in_valid && (r_bcnt == 2'd3)) begin
            w_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        w_next  = w_more ? S_PAYLOAD : S_CHECK;
      end
      S_CHECK: begin
        if (w_timed_out) begin
          w_next = S_ERROR;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_next = w_sum_ok ? S_DONE : S_ERROR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
        if (start) begin
          w_next = S_HDR;
        end
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) begin
          w_next = S_HDR;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: header latch, word assembly, checksum, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n    <= 8'd0;
      r_sum  <= 8'd0;
      r_addr <= 8'd0;
      r_wcnt <= 9'd0;
      r_bcnt <= 2'd0;
      r_word <= 32'd0;
      r_tmo  <= '0;
    end else begin
      case (r_state)
        S_HDR: begin
          r_tmo <= '0;
          if (w_accept) begin
            r_n    <= in_data;
            r_sum  <= in_data;
            r_addr <= 8'd0;
            r_wcnt <= 9'd0;
            r_bcnt <= 2'd0;
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_word <= {r_word[23:0], in_data};
            r_sum  <= w_sum_add;
            r_bcnt <= r_bcnt + 2'd1;
            r_tmo  <= '0;
          end else if (TMO_EN && !w_timed_out) begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_WRITE: begin
          r_wcnt <= w_wcnt_inc;
          // Address only advances when another word follows, so with N=0
          // it stops at 255 instead of wrapping back to 0.
          if (w_more) begin
            r_addr <= r_addr + 8'd1;
            r_tmo  <= '0;
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_sum <= w_sum_add;
            r_tmo <= '0;
          end else if (TMO_EN && !w_timed_out) begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader
module tb_boot_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        start;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  img_q[$];
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  exp_a[$];
  logic [31:0] exp_d[$];
  logic        prev_we;

  boot_loader #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        dn;
    logic        er;
    logic        run;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic rdy,
                              input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic dn, input logic er, input logic run);
    vec_t v;
    v.vld = vld; v.dat = dat; v.rdy = rdy; v.we = we; v.addr = addr;
    v.wdata = wdata; v.dn = dn; v.er = er; v.run = run;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe is captured, must be a single cycle and
  // must coincide with in_ready low.
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      check("we_ready_low", in_ready, 0);
      check("we_single_cycle", prev_we, 0);
    end
    prev_we = imem_we;
  end

  // Called at a negedge; asserts reset, checks outputs cleared, releases at next negedge.
  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; start = 1'b0;
    #1;
    check("reset_outputs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_run, done, error}, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_byte: in_ready stuck low for byte %0h", b);
    end
    @(negedge clk);
  endtask

  task automatic send_image();
    foreach (img_q[i]) send_byte(img_q[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!done && !error && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done && !error) begin
      n_vec++; n_err++;
      $display("FAIL wait_end: no done/error after %0d cycles", max);
    end
  endtask

  task automatic check_writes(input string name);
    check({name, "_count"}, wa_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      check($sformatf("%s_w%0d", name, i), {wa_q[i], wd_q[i]}, {exp_a[i], exp_d[i]});
    end
  endtask

  task automatic clear_writes();
    wa_q.delete(); wd_q.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic load_good(input logic [7:0] csum);
    img_q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, csum};
    exp_a = '{8'h00, 8'h01};
    exp_d = '{32'h01020304, 32'h05060708};
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] sum;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0; prev_we = 1'b0;

    // Cycle-accurate good load straight out of reset.
    tbl[0]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 8'h02, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[2]  = mk(1, 8'h01, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[3]  = mk(1, 8'h02, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[4]  = mk(1, 8'h03, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[5]  = mk(1, 8'h04, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 1, 8'h00, 32'h01020304, 0, 0, 0);
    tbl[7]  = mk(1, 8'h05, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[8]  = mk(1, 8'h06, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[9]  = mk(1, 8'h07, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[10] = mk(1, 8'h08, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 1, 8'h01, 32'h05060708, 0, 0, 0);
    tbl[12] = mk(1, 8'hDA, 1, 0, 8'h00, 32'h0,        0, 0, 0);
    tbl[13] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 1);
    tbl[14] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 1);

    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("tbl%0d_ctl", i), {in_ready, imem_we, done, error, cpu_run},
            {tbl[i].rdy, tbl[i].we, tbl[i].dn, tbl[i].er, tbl[i].run});
      if (tbl[i].we) begin
        check($sformatf("tbl%0d_write", i), {imem_addr, imem_wdata}, {tbl[i].addr, tbl[i].wdata});
      end
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Bad checksum, then restart and reload with continuous in_valid.
    do_reset();
    clear_writes();
    load_good(8'hDB);
    send_image();
    wait_end(20);
    check("bad_flags", {done, error, cpu_run}, 3'b010);
    check_writes("bad");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_hdr", {in_ready, done, error, cpu_run}, 4'b1000);
    clear_writes();
    load_good(8'hDA);
    send_image();
    wait_end(20);
    check("reload_flags", {done, error, cpu_run}, 3'b101);
    check_writes("reload");

    // Timeout after partial word: error exactly 17 cycles after last accept.
    do_reset();
    clear_writes();
    img_q = '{8'h02, 8'h01, 8'h02, 8'h03};
    send_image();
    repeat (16) @(negedge clk);
    check("tmo_before", error, 0);
    @(negedge clk);
    check("tmo_at17", {error, done, cpu_run}, 3'b100);
    check("tmo_no_write", wa_q.size(), 0);

    // Reset after 6 payload bytes, then a fresh load starts at address 0.
    do_reset();
    clear_writes();
    img_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_image();
    check("midload_one_write", wa_q.size(), 1);
    do_reset();
    clear_writes();
    load_good(8'hDA);
    send_image();
    wait_end(20);
    check("after_reset_flags", {done, error, cpu_run}, 3'b101);
    check_writes("after_reset");

    // Full 256-word image.
    do_reset();
    clear_writes();
    img_q.delete();
    img_q.push_back(8'h00);
    sum = 8'h00;
    for (int k = 0; k < 256; k++) begin
      logic [31:0] w;
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b = 8'((k * 4 + j) * 37 + 11);
        img_q.push_back(b);
        sum = sum + b;
        w = {w[23:0], b};
      end
      exp_a.push_back(8'(k));
      exp_d.push_back(w);
    end
    img_q.push_back(8'(0) - sum);
    send_image();
    wait_end(20);
    check("full_flags", {done, error, cpu_run}, 3'b101);
    check_writes("full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
